// File: rtl/muldiv_arb_pkg.sv
// Shared types for the mul/div arbiter: operation select and FSM states.
// Imported by the arbiter top and its round-robin picker.
package muldiv_arb_pkg;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first valid index at or after ptr_i, wrapping.
// Produces a one-hot (or zero) grant vector.
module rr_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o
);

  always_comb begin
    int j;
    grant_o = '0;
    j = 0;
    // walk offsets high to low so the smallest offset wins
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative multiplier and one divider among NUM_REQ requesters.
// DIV_ZERO_BYPASS_EN: answer DIV by zero locally with all-ones and error.
module muldiv_arbiter
  import muldiv_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  op_t  [NUM_REQ-1:0]       req_op_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WIDTH-1:0]         op_a_o,
  output logic [WIDTH-1:0]         op_b_o,
  output logic                     mul_v_o,
  input  logic                     mul_ready_i,
  input  logic                     mul_v_i,
  input  logic [WIDTH-1:0]         mul_result_i,
  output logic                     mul_yumi_o,
  output logic                     div_v_o,
  input  logic                     div_ready_i,
  input  logic                     div_v_i,
  input  logic [WIDTH-1:0]         div_result_i,
  output logic                     div_yumi_o
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t       state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gidx;
  logic [WIDTH-1:0]   ga;
  logic [WIDTH-1:0]   gb;
  op_t                gop;
  logic               byp;
  logic               sel_rdy;
  logic               sel_v;
  logic [WIDTH-1:0]   sel_res;
  logic               in_resp;

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gidx = '0;
    ga   = '0;
    gb   = '0;
    gop  = MUL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx = IDW'(i);
        ga   = req_a_i[i*WIDTH +: WIDTH];
        gb   = req_b_i[i*WIDTH +: WIDTH];
        gop  = req_op_i[i];
      end
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic err_q;
  assign byp = (gop == DIV) && (gb == '0);
`else
  assign byp = 1'b0;
`endif

  assign sel_rdy = (op_q == DIV) ? div_ready_i : mul_ready_i;
  assign sel_v   = (op_q == DIV) ? div_v_i : mul_v_i;
  assign sel_res = (op_q == DIV) ? div_result_i : mul_result_i;
  assign in_resp = (state_q == RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= MUL;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            id_q <= gidx;
            op_q <= gop;
            a_q  <= ga;
            b_q  <= gb;
            if (byp) begin
              data_q  <= '1;
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
`ifdef DIV_ZERO_BYPASS_EN
            err_q <= byp;
`endif
          end
        end
        ISSUE: if (sel_rdy) state_q <= WAIT;
        WAIT: begin
          if (sel_v) begin
            data_q  <= sel_res;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i[id_q]) begin
            state_q <= IDLE;
            ptr_q   <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // grant is combinational, so mask it while reset is held
  assign req_ready_o = (rst_ni && state_q == IDLE) ? grant : '0;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = in_resp && (id_q == IDW'(i));
    end
  end

  assign rsp_data_o = in_resp ? data_q : '0;
`ifdef DIV_ZERO_BYPASS_EN
  assign rsp_err_o  = in_resp && err_q;
`else
  assign rsp_err_o  = 1'b0;
`endif

  assign op_a_o     = a_q;
  assign op_b_o     = b_q;
  assign mul_v_o    = (state_q == ISSUE) && (op_q == MUL);
  assign div_v_o    = (state_q == ISSUE) && (op_q == DIV);
  assign mul_yumi_o = (state_q == WAIT) && (op_q == MUL) && mul_v_i;
  assign div_yumi_o = (state_q == WAIT) && (op_q == DIV) && div_v_i;

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter
Interface
REQ-001 WIDTH, 32, operand and result width in bits.
REQ-002 NUM_REQ, 2, number of requesters (legal range 2..4).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i  in  NUM_REQ  per-requester command valid.
REQ-006 req_ready_o  out  NUM_REQ  per-requester command accept (one-hot or zero).
REQ-007 req_op_i  in  NUM_REQ x op_t  per-requester operation select (MUL=0, DIV=1).
REQ-008 req_a_i  in  NUM_REQ*WIDTH  per-requester operand A (multiplicand or dividend), packed by index.
REQ-009 req_b_i  in  NUM_REQ*WIDTH  per-requester operand B (multiplier or divisor), packed by index.
REQ-010 rsp_valid_o  out  NUM_REQ  result valid, asserted only for the owning requester.
REQ-011 rsp_ready_i  in  NUM_REQ  per-requester result accept.
REQ-012 rsp_data_o  out  WIDTH  result; product low part or quotient.
REQ-013 rsp_err_o  out  1  divide-by-zero flag, qualified by rsp_valid_o.
REQ-014 op_a_o  out  WIDTH  operand A driven to both shared units.
REQ-015 op_b_o  out  WIDTH  operand B driven to both shared units.
REQ-016 mul_v_o  out  1  issue valid to the iterative multiplier.
REQ-017 mul_ready_i  in  1  multiplier ready_and.
REQ-018 mul_v_i  in  1  multiplier result valid.
REQ-019 mul_result_i  in  WIDTH  multiplier result.
REQ-020 mul_yumi_o  out  1  multiplier result consume.
REQ-021 div_v_o  out  1  issue valid to the iterative divider.
REQ-022 div_ready_i  in  1  divider ready_and.
REQ-023 div_v_i  in  1  divider result valid.
REQ-024 div_result_i  in  WIDTH  divider quotient.
REQ-025 div_yumi_o  out  1  divider result consume.
Function
REQ-026 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with at most one operation outstanding.
REQ-027 IDLE: when any req_valid_i bit is high, grant the first valid index at or after the round-robin pointer (wrapping modulo NUM_REQ); assert req_ready_o[grant] in that same cycle; capture op, a, b and the grant id; go to ISSUE.
REQ-028 req_ready_o SHALL be all zero in every state other than IDLE; requesters not granted wait, and a requester may drop req_valid_i before it is granted.
REQ-029 ISSUE: assert mul_v_o or div_v_o according to the captured op; op_a_o and op_b_o SHALL hold the captured operands, stable while the valid is high; go to WAIT on the cycle the selected ready_i is high.
REQ-030 WAIT: on the selected unit's v_i, register its result and pulse the matching yumi_o in the same cycle; go to RESP. A v_i from the non-selected unit SHALL be ignored, with its yumi_o held low.
REQ-031 RESP: drive rsp_valid_o[id] high with rsp_data_o held stable; on rsp_ready_i[id], return to IDLE and set the pointer to (id+1) mod NUM_REQ.
REQ-032 Minimum latency from command accept to rsp_valid_o SHALL be 3 cycles plus the unit's compute time.
REQ-033 The block SHALL perform no arithmetic; results pass through bit-exact, and signedness is configured in the units.
REQ-034 rsp_data_o and rsp_err_o SHALL be zero whenever no rsp_valid_o bit is high.
Reset
REQ-035 While rst_ni is low: state = IDLE, pointer = 0, and all outputs and captured registers = 0, applied immediately without waiting for a clock edge.
REQ-036 Reset asserted mid-operation SHALL discard the pending operation without a response; resetting the shared units is the parent's responsibility.
Configuration
REQ-037 DIV_ZERO_BYPASS_EN defined: a DIV command with b==0 SHALL go IDLE->RESP directly, with rsp_data_o all-ones, rsp_err_o=1 and div_v_o never asserted. Not defined: the command is forwarded to the divider as normal and rsp_err_o is tied to 0.
Structure
REQ-038 Package muldiv_arb_pkg SHALL hold op_t and arb_state_t.
REQ-039 The round-robin pick logic SHALL be a separate sub-module, rr_picker (inputs: valid vector and pointer; output: one-hot grant).
Verification
REQ-040 Single MUL on req0 with a=7, b=-3; unit returns 0xFFFFFFEB -> rsp_valid_o[0]=1, rsp_data_o=0xFFFFFFEB, mul_yumi_o pulses once.
REQ-041 Both requesters valid on the first cycle after reset -> req0 served first, then req1; the next simultaneous pair -> req0 served first again.
REQ-042 rsp_ready_i held low for 10 cycles during RESP -> rsp_data_o held stable, req_ready_o all zero, no unit valid asserted.
REQ-043 DIV 100/7 on req1 -> rsp_data_o=14 on rsp_valid_o[1]. With DIV_ZERO_BYPASS_EN, DIV 5/0 -> rsp_data_o=0xFFFFFFFF, rsp_err_o=1, div_v_o stays 0.
REQ-044 rst_ni pulsed low during WAIT -> all outputs 0 with no clock edge, no response issued, and the next request is granted from pointer 0.
